src_ctrl: RTL and testbench
===========================

# src_ctrl

Input-side stream controller: the receive counterpart of the output stream controller. Accepts a valid/ready/last word stream from the host DMA and writes each word into the local 2^AW-entry stream buffer through a registered write port. Once a packet is complete it reports it to the compute side via `stream_ok`/`stream_len`, and holds off the source until the consumer releases the buffer with `stream_ack`.

## Interface
- `DW`, 32, data word width
- `AW`, 5, buffer address width; depth = 2^AW words (32)

- `clk`  in  1  clock, all logic on rising edge
- `run`  in  1  reset, asynchronous, active-low; low clears all state
- `src_valid`  in  1  source word valid
- `src_last`  in  1  final word of packet, qualified by `src_valid`
- `src_data`  in  DW  source word
- `src_ready`  out  1  controller can accept a word
- `buf_we`  out  1  buffer write enable, registered
- `buf_a`  out  AW  buffer write address, registered
- `buf_d`  out  DW  buffer write data, registered
- `stream_ok`  out  1  complete packet resident in buffer (level)
- `stream_len`  out  AW+1  word count of resident packet, 1..2^AW
- `stream_ack`  in  1  consumer releases buffer; honoured only while `stream_ok`=1
- `ovf`  out  1  sticky overflow flag (tied 0 without the macro)

## Operation
- States: RECV, COMMIT, HOLD, DROP (DROP exists only with the macro).
- Reset (`run`=0): state RECV; `src_ready`=0 during reset, 1 from the first edge after release; `buf_we`=0, `buf_a`=0, `buf_d`=0, `stream_ok`=0, `stream_len`=0, `ovf`=0; word counter=0.
- `src_ready` = (state==RECV), decoded from the state register only, with no combinational path from `src_valid`.
- Accept = `src_valid & src_ready`. Each accept writes `src_data` at address = counter, then increments the counter (AW+1 bits).
- RECV→COMMIT when the accepted word has `src_last`=1, or when it is word 2^AW (counter reaches 2^AW).
- COMMIT lasts one cycle (`src_ready`=0) so the final write lands before the consumer is told. COMMIT→HOLD always.
- HOLD: `stream_ok`=1, `stream_len`=counter. On `stream_ack`: → RECV, counter cleared, `stream_ok`=0.
- `stream_ack` in RECV/COMMIT/DROP is ignored.
- Overflow without `src_last` (word 2^AW accepted with `src_last`=0): the packet closes at 2^AW words. Behaviour of the remaining words depends on the macro.
- `src_valid` low mid-packet: no write, state unchanged, no timeout.

## Timing
- Accept at edge t → `buf_we`/`buf_a`/`buf_d` valid in cycle t+1, for exactly one cycle.
- Last accept at edge t → state COMMIT in cycle t+1 (final `buf_we` visible) → `stream_ok`=1 in cycle t+2.
- `stream_ack` sampled high at edge h in HOLD → `stream_ok`=0 and `src_ready`=1 in cycle h+1. Earliest new accept is at edge h+1.
- Back-to-back full-rate input: one word per cycle while in RECV.
- Minimum per-packet overhead: COMMIT cycle plus the HOLD residency.
- `run` low at any time aborts immediately (asynchronous). A partial packet is discarded, buffer contents are undefined, and `stream_ok` is not asserted for it.

## Configuration
- `SRC_CTRL_OVF_DROP_EN` defined:
  - An overflow enters DROP instead of COMMIT.
  - In DROP, `src_ready`=1, `buf_we`=0, and words are discarded until an accepted `src_last`, then → COMMIT with `stream_len`=2^AW.
  - `ovf` sets in the cycle after entering DROP and stays set until reset.
- Not defined:
  - Overflow goes straight to COMMIT; the following words form the next packet.
  - No DROP state; `ovf` is constant 0.

## Structure
- Shared package `hpu_stream_pkg`: state enum `src_state_t`, default `DW`/`AW` localparams. `stream_len` width derives from `AW`.
- One sub-module, `src_agu`: AW+1-bit write counter with clear, enable and `full` output (count==2^AW). Instantiated once; the FSM and output registers live in `src_ctrl`.

## Test plan
- Reset, then a 4-word packet `0x10..0x13`, last on word 4 → writes at a=0..3, `stream_ok`=1 two cycles after the last accept, `stream_len`=4, `src_ready`=0 until `stream_ack`.
- Source with a 1-cycle valid gap every other word, 3 words → no write on gap cycles, addresses contiguous 0..2, `stream_len`=3.
- 32 words, last on word 32 → a=31 written, `stream_len`=32, `ovf`=0.
- 35 words, last on word 35:
  - With macro: 32 writes, words 33–35 dropped, `stream_len`=32, `ovf`=1.
  - Without macro: first packet `stream_len`=32; after `stream_ack` the second packet is `stream_len`=3 at a=0..2.
- `stream_ack` pulsed during RECV and COMMIT → ignored. Ack in HOLD → `src_ready` high the next cycle, next packet starts at a=0.
- `run` dropped after 5 accepted words of a packet, then re-raised → all outputs at reset values, no `stream_ok`. A new 2-word packet writes a=0..1, `stream_len`=2.

Source files
------------

// File: rtl/hpu_stream_pkg.sv
// Shared types and defaults for the HPU stream controllers.
package hpu_stream_pkg;

  localparam int unsigned DefDw = 32;
  localparam int unsigned DefAw = 5;

  // Receive-side controller states; StDrop is only reachable when overflow dropping is built in.
  typedef enum logic [1:0] {
    StRecv   = 2'd0,
    StCommit = 2'd1,
    StHold   = 2'd2,
    StDrop   = 2'd3
  } src_state_t;

endpackage

// File: rtl/src_agu.sv
// Write address generator for the input stream buffer: AW+1-bit word counter.
module src_agu
  import hpu_stream_pkg::*;
#(
  parameter int unsigned AW = DefAw
) (
  input  logic        clk,
  input  logic        run,
  input  logic        clr,
  input  logic        en,
  output logic [AW:0] count,
  output logic        full
);

  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

  logic [AW:0] cnt_q;

  // Counter: clear has priority over increment.
  always_ff @(posedge clk or negedge run) begin
    if (!run) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;
  assign full  = (cnt_q == Depth);

endmodule

// File: rtl/src_ctrl.sv
// Input-side stream controller: host DMA word stream -> local stream buffer.
// Optional feature: define SRC_CTRL_OVF_DROP_EN to discard the tail of an oversize
// packet (DROP state) and raise the sticky ovf flag.
module src_ctrl
  import hpu_stream_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned AW = DefAw
) (
  input  logic          clk,
  input  logic          run,
  input  logic          src_valid,
  input  logic          src_last,
  input  logic [DW-1:0] src_data,
  output logic          src_ready,
  output logic          buf_we,
  output logic [AW-1:0] buf_a,
  output logic [DW-1:0] buf_d,
  output logic          stream_ok,
  output logic [AW:0]   stream_len,
  input  logic          stream_ack,
  output logic          ovf
);

  // Count value while the 2^AW-th word is being accepted.
  localparam logic [AW:0] LastIdx = {1'b0, {AW{1'b1}}};

  src_state_t state_q, state_d;

  logic          ready_q;
  logic          we_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q;
  logic          ok_q;
  logic [AW:0]   len_q;

  logic [AW:0] count;
  logic        full;
  logic        accept;
  logic        wr_en;
  logic        cnt_clr;
  logic        at_end;

  assign accept  = src_valid & ready_q;
  assign wr_en   = accept & (state_q == StRecv) & ~full;
  assign at_end  = (count == LastIdx);
  assign cnt_clr = (state_q == StHold) & stream_ack;

  src_agu #(
    .AW(AW)
  ) u_agu (
    .clk  (clk),
    .run  (run),
    .clr  (cnt_clr),
    .en   (wr_en),
    .count(count),
    .full (full)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRecv: begin
        if (wr_en && src_last) begin
          state_d = StCommit;
        end else if (wr_en && at_end) begin
`ifdef SRC_CTRL_OVF_DROP_EN
          state_d = StDrop;
`else
          state_d = StCommit;
`endif
        end
      end
      StCommit: state_d = StHold;
      StHold: begin
        if (stream_ack) begin
          state_d = StRecv;
        end
      end
`ifdef SRC_CTRL_OVF_DROP_EN
      StDrop: begin
        if (accept && src_last) begin
          state_d = StCommit;
        end
      end
`endif
      default: state_d = StRecv;
    endcase
  end

  // State and registered outputs; ready/ok/len are decoded from the next state so they
  // line up with the state register.
  always_ff @(posedge clk or negedge run) begin
    if (!run) begin
      state_q <= StRecv;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= '0;
      d_q     <= '0;
      ok_q    <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StRecv) || (state_d == StDrop);
      we_q    <= wr_en;
      if (wr_en) begin
        a_q <= count[AW-1:0];
        d_q <= src_data;
      end
      ok_q  <= (state_d == StHold);
      len_q <= (state_d == StHold) ? count : '0;
    end
  end

`ifdef SRC_CTRL_OVF_DROP_EN
  logic ovf_q;

  // Sticky overflow: set once DROP has been resident for a cycle, cleared only by reset.
  always_ff @(posedge clk or negedge run) begin
    if (!run) begin
      ovf_q <= 1'b0;
    end else if (state_q == StDrop) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign src_ready  = ready_q;
  assign buf_we     = we_q;
  assign buf_a      = a_q;
  assign buf_d      = d_q;
  assign stream_ok  = ok_q;
  assign stream_len = len_q;

endmodule

// File: tb/tb_src_ctrl.sv
// Directed bench for src_ctrl; expected values are hand-derived constants.
module tb_src_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          run = 1'b0;
  logic          src_valid = 1'b0;
  logic          src_last = 1'b0;
  logic [DW-1:0] src_data = '0;
  logic          src_ready;
  logic          buf_we;
  logic [AW-1:0] buf_a;
  logic [DW-1:0] buf_d;
  logic          stream_ok;
  logic [AW:0]   stream_len;
  logic          stream_ack = 1'b0;
  logic          ovf;

  int total = 0;
  int bad = 0;

  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];

  src_ctrl #(
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk       (clk),
    .run       (run),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_data  (src_data),
    .src_ready (src_ready),
    .buf_we    (buf_we),
    .buf_a     (buf_a),
    .buf_d     (buf_d),
    .stream_ok (stream_ok),
    .stream_len(stream_len),
    .stream_ack(stream_ack),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Buffer write log.
  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      wa.push_back(buf_a);
      wd.push_back(buf_d);
    end
  end

  // Presents one word from a negedge and returns at the negedge after it was accepted.
  task automatic send_word(input logic [DW-1:0] d, input logic last);
    int n = 0;
    src_valid = 1'b1;
    src_data  = d;
    src_last  = last;
    while (src_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: src_ready stuck at %b, required 1", src_ready);
    end
    @(negedge clk);
    src_valid = 1'b0;
    src_last  = 1'b0;
  endtask

  task automatic pulse_ack();
    stream_ack = 1'b1;
    @(negedge clk);
    stream_ack = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({src_ready, buf_we, buf_a, buf_d, stream_ok, stream_len, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: rdy=%b we=%b a=%0d d=%h ok=%b len=%0d ovf=%b, required all 0",
               src_ready, buf_we, buf_a, buf_d, stream_ok, stream_len, ovf);
    end
    run = 1'b1;
    @(negedge clk);
    total++;
    if (src_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b, required 1", src_ready);
    end
  endtask

  task automatic test_basic();
    wa.delete();
    wd.delete();
    for (int i = 0; i < 4; i++) send_word(32'h10 + i, i == 3);
    total++;
    if (stream_ok !== 1'b0 || src_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_commit: ok=%b rdy=%b, required ok=0 rdy=0", stream_ok, src_ready);
    end
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd4 || src_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: ok=%b len=%0d rdy=%b, required ok=1 len=4 rdy=0",
               stream_ok, stream_len, src_ready);
    end
    repeat (3) @(negedge clk);
    total++;
    if (src_ready !== 1'b0 || stream_ok !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold_wait: rdy=%b ok=%b, required rdy=0 ok=1", src_ready, stream_ok);
    end
    total++;
    if (wa.size() != 4) begin
      bad++;
      $display("FAIL basic_nwrites: got %0d, required 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wa[i] !== 5'(i) || wd[i] !== 32'h10 + i) begin
          bad++;
          $display("FAIL basic_write%0d: a=%0d d=%h, required a=%0d d=%h",
                   i, wa[i], wd[i], i, 32'h10 + i);
        end
      end
    end
    pulse_ack();
    total++;
    if (stream_ok !== 1'b0 || src_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ack: ok=%b rdy=%b, required ok=0 rdy=1", stream_ok, src_ready);
    end
  endtask

  task automatic test_gaps();
    wa.delete();
    wd.delete();
    for (int i = 0; i < 3; i++) begin
      send_word(32'hA0 + i, i == 2);
      if (i < 2) begin
        @(negedge clk);
        total++;
        if (buf_we !== 1'b0) begin
          bad++;
          $display("FAIL gap_no_write%0d: we=%b, required 0", i, buf_we);
        end
      end
    end
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd3) begin
      bad++;
      $display("FAIL gap_len: ok=%b len=%0d, required ok=1 len=3", stream_ok, stream_len);
    end
    total++;
    if (wa.size() != 3) begin
      bad++;
      $display("FAIL gap_nwrites: got %0d, required 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wa[i] !== 5'(i) || wd[i] !== 32'hA0 + i) begin
          bad++;
          $display("FAIL gap_write%0d: a=%0d d=%h, required a=%0d d=%h",
                   i, wa[i], wd[i], i, 32'hA0 + i);
        end
      end
    end
    pulse_ack();
  endtask

  task automatic test_full();
    wa.delete();
    wd.delete();
    for (int i = 0; i < 32; i++) send_word(32'h200 + i, i == 31);
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd32 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL full_hold: ok=%b len=%0d ovf=%b, required ok=1 len=32 ovf=0",
               stream_ok, stream_len, ovf);
    end
    total++;
    if (wa.size() != 32 || wa[wa.size()-1] !== 5'd31 || wd[wd.size()-1] !== 32'h21F) begin
      bad++;
      $display("FAIL full_writes: n=%0d, required 32 ending at a=31 d=21f", wa.size());
    end
    pulse_ack();
  endtask

  task automatic test_overflow();
    wa.delete();
    wd.delete();
`ifdef SRC_CTRL_OVF_DROP_EN
    for (int i = 0; i < 35; i++) send_word(32'h300 + i, i == 34);
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd32 || ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_drop_hold: ok=%b len=%0d ovf=%b, required ok=1 len=32 ovf=1",
               stream_ok, stream_len, ovf);
    end
    total++;
    if (wa.size() != 32 || wd[wd.size()-1] !== 32'h31F) begin
      bad++;
      $display("FAIL ovf_drop_writes: n=%0d, required 32 ending at d=31f", wa.size());
    end
    pulse_ack();
`else
    for (int i = 0; i < 32; i++) send_word(32'h300 + i, 1'b0);
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd32 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL ovf_split_first: ok=%b len=%0d ovf=%b, required ok=1 len=32 ovf=0",
               stream_ok, stream_len, ovf);
    end
    pulse_ack();
    wa.delete();
    wd.delete();
    for (int i = 32; i < 35; i++) send_word(32'h300 + i, i == 34);
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd3) begin
      bad++;
      $display("FAIL ovf_split_second: ok=%b len=%0d, required ok=1 len=3", stream_ok, stream_len);
    end
    total++;
    if (wa.size() != 3 || wa[0] !== 5'd0 || wa[2] !== 5'd2 || wd[0] !== 32'h320) begin
      bad++;
      $display("FAIL ovf_split_writes: n=%0d, required 3 at a=0..2 starting d=320", wa.size());
    end
    pulse_ack();
`endif
  endtask

  task automatic test_ack_ignored();
    wa.delete();
    wd.delete();
    send_word(32'h40, 1'b0);
    pulse_ack();
    send_word(32'h41, 1'b1);
    // Now in COMMIT: hold ack across the COMMIT edge.
    stream_ack = 1'b1;
    @(negedge clk);
    stream_ack = 1'b0;
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd2) begin
      bad++;
      $display("FAIL ack_ignored: ok=%b len=%0d, required ok=1 len=2", stream_ok, stream_len);
    end
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || src_ready !== 1'b0) begin
      bad++;
      $display("FAIL ack_ignored_hold: ok=%b rdy=%b, required ok=1 rdy=0", stream_ok, src_ready);
    end
    pulse_ack();
    total++;
    if (src_ready !== 1'b1 || stream_ok !== 1'b0) begin
      bad++;
      $display("FAIL ack_release: rdy=%b ok=%b, required rdy=1 ok=0", src_ready, stream_ok);
    end
    wa.delete();
    wd.delete();
    send_word(32'h50, 1'b1);
    total++;
    if (buf_we !== 1'b1 || buf_a !== 5'd0 || buf_d !== 32'h50) begin
      bad++;
      $display("FAIL ack_next_addr: we=%b a=%0d d=%h, required we=1 a=0 d=50",
               buf_we, buf_a, buf_d);
    end
    @(negedge clk);
    pulse_ack();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 5; i++) send_word(32'h60 + i, 1'b0);
    run = 1'b0;
    #1;
    total++;
    if ({src_ready, buf_we, buf_a, buf_d, stream_ok, stream_len, ovf} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: rdy=%b we=%b a=%0d d=%h ok=%b len=%0d ovf=%b, required all 0",
               src_ready, buf_we, buf_a, buf_d, stream_ok, stream_len, ovf);
    end
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    wa.delete();
    wd.delete();
    total++;
    if (stream_ok !== 1'b0 || src_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_restart: ok=%b rdy=%b, required ok=0 rdy=1", stream_ok, src_ready);
    end
    send_word(32'h70, 1'b0);
    send_word(32'h71, 1'b1);
    @(negedge clk);
    total++;
    if (stream_ok !== 1'b1 || stream_len !== 6'd2) begin
      bad++;
      $display("FAIL abort_new_pkt: ok=%b len=%0d, required ok=1 len=2", stream_ok, stream_len);
    end
    total++;
    if (wa.size() != 2 || wa[0] !== 5'd0 || wa[1] !== 5'd1 || wd[1] !== 32'h71) begin
      bad++;
      $display("FAIL abort_new_writes: n=%0d, required 2 at a=0..1", wa.size());
    end
    pulse_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_full();
    test_overflow();
    test_ack_ignored();
    test_abort();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
